pio_in_edge_capture: RTL and testbench

- Parameterised Avalon-MM slave parallel input port; next generation of the team's 8-bit read-only input PIO.
- Adds synchronisation, optional per-bit debounce, per-bit edge capture with write-1-to-clear, interrupt mask and an irq output.
- Sits between board-level inputs (switches, buttons) and the Nios II data master.

---
 rtl/pio_in_edge_capture_if.sv | 20 ++
 rtl/pio_in_edge_capture.sv | 113 +++++++++++
 tb/tb_pio_in_edge_capture.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_in_edge_capture_if.sv
// Avalon-MM slave bus bundle for the edge-capturing parallel input port.
// The host drives the request fields and the port returns registered read data.
`timescale 1ns/1ps
interface pio_in_edge_capture_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_in_edge_capture.sv
// Parallel input port with synchroniser, optional per-bit debounce, edge capture
// (write 1 to clear), interrupt mask and irq output on an Avalon-MM slave.
`timescale 1ns/1ps
module pio_in_edge_capture #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0,
  parameter int IRQ_TYPE        = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pio_in_edge_capture_if.slave bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] clear_bits;
  logic             wr_en;
  logic [31:0]      rd_next;
  logic             unused_writedata;

  assign unused_writedata = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Each bit only accepts a new level after it has differed from the
  // accepted level for DEBOUNCE_CYCLES consecutive clocks.
  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
      assign stable = sync;
    end else begin : g_debounce
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CW-1:0] count;
        logic          level;

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            count <= '0;
            level <= 1'b0;
          end else if (sync[i] == level) begin
            count <= '0;
          end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync[i];
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end

        assign stable[i] = level;
      end
    end
  endgenerate

  always_comb begin
    edges = '0;
    case (EDGE_TYPE)
      0:       edges = stable & ~prev;
      1:       edges = ~stable & prev;
      default: edges = stable ^ prev;
    endcase
  end

  assign wr_en      = bus.chipselect & ~bus.write_n;
  assign clear_bits = (wr_en && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_next = '0;
    case (bus.address)
      2'd0:    rd_next[WIDTH-1:0] = stable;
      2'd1:    rd_next[WIDTH-1:0] = irq_mask;
      2'd2:    rd_next[WIDTH-1:0] = edge_capture;
      default: rd_next[WIDTH-1:0] = sync;
    endcase
  end

  // A new edge outranks a simultaneous software clear so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev         <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      bus.readdata <= '0;
    end else begin
      prev         <= stable;
      edge_capture <= (edge_capture & ~clear_bits) | edges;
      bus.readdata <= rd_next;
      if (wr_en && bus.address == 2'd1) irq_mask <= bus.writedata[WIDTH-1:0];
    end
  end

  assign irq = (IRQ_TYPE == 1) ? |(edge_capture & irq_mask) : |(stable & irq_mask);

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// Drives three port variants (plain, debounced, any-edge/level-irq) with shared
// directed and random stimulus and compares them to a behavioural model.
`timescale 1ns/1ps
module tb_pio_in_edge_capture;

  typedef struct packed {
    logic [7:0]      pipe0;
    logic [7:0]      pipe1;
    logic [7:0]      last_sync;
    logic [7:0][7:0] run;
    logic [7:0]      stable;
    logic [7:0]      stable_before;
    logic [7:0]      mask;
    logic [7:0]      cap;
    logic [31:0]     rd;
  } model_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  pins = '0;
  logic [1:0]  addr = '0;
  logic        cs = 1'b0;
  logic        wn = 1'b1;
  logic [31:0] wd = '0;
  logic        irq_a, irq_b, irq_c;
  model_t      m_a, m_b, m_c;
  int          checks = 0;
  int          errors = 0;

  pio_in_edge_capture_if bus_a ();
  pio_in_edge_capture_if bus_b ();
  pio_in_edge_capture_if bus_c ();

  assign bus_a.address = addr;  assign bus_a.chipselect = cs;
  assign bus_a.write_n = wn;    assign bus_a.writedata  = wd;
  assign bus_b.address = addr;  assign bus_b.chipselect = cs;
  assign bus_b.write_n = wn;    assign bus_b.writedata  = wd;
  assign bus_c.address = addr;  assign bus_c.chipselect = cs;
  assign bus_c.write_n = wn;    assign bus_c.writedata  = wd;

  pio_in_edge_capture dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(pins), .irq(irq_a));

  pio_in_edge_capture #(.DEBOUNCE_CYCLES(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .in_port(pins), .irq(irq_b));

  pio_in_edge_capture #(.EDGE_TYPE(2), .IRQ_TYPE(0)) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(bus_c), .in_port(pins), .irq(irq_c));

  always #5 clk = ~clk;

  // A bit is accepted once the synchronised input has held its new value for d
  // consecutive clocks; a capture bit sets when the accepted value moved.
  function automatic model_t model_step(model_t m, logic [7:0] p, logic wr,
                                        logic [1:0] a, logic [31:0] w, int d, int edge_sel);
    model_t     n = m;
    logic [7:0] rise, fall, seen, clr;
    n.pipe0 = p;
    n.pipe1 = m.pipe0;
    case (a)
      2'd0:    n.rd = {24'h0, m.stable};
      2'd1:    n.rd = {24'h0, m.mask};
      2'd2:    n.rd = {24'h0, m.cap};
      default: n.rd = {24'h0, m.pipe1};
    endcase
    for (int i = 0; i < 8; i++) begin
      if (m.pipe1[i] == m.last_sync[i] && m.run[i] != 8'd0)
        n.run[i] = (m.run[i] == 8'hFF) ? m.run[i] : m.run[i] + 8'd1;
      else
        n.run[i] = 8'd1;
    end
    n.last_sync = m.pipe1;
    if (d == 0) n.stable = n.pipe1;
    else
      for (int i = 0; i < 8; i++)
        if (m.pipe1[i] != m.stable[i] && int'(n.run[i]) >= d) n.stable[i] = m.pipe1[i];
    rise = m.stable & ~m.stable_before;
    fall = ~m.stable & m.stable_before;
    seen = (edge_sel == 0) ? rise : (edge_sel == 1) ? fall : (rise | fall);
    n.stable_before = m.stable;
    clr = (wr && a == 2'd2) ? w[7:0] : 8'h00;
    n.cap = (m.cap & ~clr) | seen;
    if (wr && a == 2'd1) n.mask = w[7:0];
    return n;
  endfunction

  function automatic logic model_irq(model_t m, int irq_type);
    return (irq_type == 1) ? |(m.cap & m.mask) : |(m.stable & m.mask);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_a <= '0;
      m_b <= '0;
      m_c <= '0;
    end else begin
      m_a <= model_step(m_a, pins, cs & ~wn, addr, wd, 0, 0);
      m_b <= model_step(m_b, pins, cs & ~wn, addr, wd, 4, 0);
      m_c <= model_step(m_c, pins, cs & ~wn, addr, wd, 0, 2);
    end
  end

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".rd_a"},  bus_a.readdata, m_a.rd);
    checkValue({tag, ".rd_b"},  bus_b.readdata, m_b.rd);
    checkValue({tag, ".rd_c"},  bus_c.readdata, m_c.rd);
    checkValue({tag, ".irq_a"}, {31'h0, irq_a}, {31'h0, model_irq(m_a, 1)});
    checkValue({tag, ".irq_b"}, {31'h0, irq_b}, {31'h0, model_irq(m_b, 1)});
    checkValue({tag, ".irq_c"}, {31'h0, irq_c}, {31'h0, model_irq(m_c, 0)});
  endtask

  // Drive one clock's worth of inputs just after a falling edge, let the rising
  // edge happen, then compare everything on the next falling edge.
  task automatic applyStimulus(input string tag, input logic [7:0] p, input logic [1:0] a,
                               input logic c, input logic w_n, input logic [31:0] w);
    pins = p;
    addr = a;
    cs   = c;
    wn   = w_n;
    wd   = w;
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic idle(input string tag, input logic [1:0] a, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, pins, a, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic regWrite(input string tag, input logic [1:0] a, input logic [31:0] w);
    applyStimulus(tag, pins, a, 1'b1, 1'b0, w);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset");
    checkValue("reset_rd_a", bus_a.readdata, 32'h0);
    checkValue("reset_irq_a", {31'h0, irq_a}, 32'h0);
    reset_n = 1'b1;
    regWrite("init_clear", 2'd2, 32'hFF);

    pins = 8'hA5;
    idle("a5", 2'd0, 2);
    checkValue("a5_early_a", bus_a.readdata, 32'h0);
    idle("a5", 2'd0, 1);
    checkValue("a5_data_a", bus_a.readdata, 32'hA5);
    checkValue("a5_data_c", bus_c.readdata, 32'hA5);
    idle("a5_raw", 2'd3, 1);
    checkValue("a5_raw_a", bus_a.readdata, 32'hA5);
    checkValue("a5_raw_b", bus_b.readdata, 32'hA5);
    idle("a5_cap", 2'd2, 1);
    checkValue("a5_cap_a", bus_a.readdata, 32'hA5);
    checkValue("a5_cap_c", bus_c.readdata, 32'hA5);
    idle("settle", 2'd0, 6);
    regWrite("clear", 2'd2, 32'hFF);
    pins = 8'h00;
    idle("settle", 2'd0, 8);
    regWrite("clear", 2'd2, 32'hFF);

    regWrite("mask01", 2'd1, 32'h1);
    pins = 8'h01;
    idle("irq_rise", 2'd0, 2);
    checkValue("irq_early_a", {31'h0, irq_a}, 32'h0);
    idle("irq_rise", 2'd0, 1);
    checkValue("irq_set_a", {31'h0, irq_a}, 32'h1);
    regWrite("irq_clear", 2'd2, 32'h1);
    checkValue("irq_cleared_a", {31'h0, irq_a}, 32'h0);

    pins = 8'h09;
    idle("simul", 2'd0, 2);
    regWrite("simul_clear", 2'd2, 32'h08);
    idle("simul_read", 2'd2, 1);
    checkValue("simul_bit3_a", bus_a.readdata & 32'h08, 32'h08);

    idle("db_settle", 2'd0, 8);
    regWrite("db_clear", 2'd2, 32'hFF);
    pins = 8'h0B;
    idle("db_glitch", 2'd0, 3);
    pins = 8'h09;
    idle("db_glitch", 2'd0, 6);
    checkValue("db_glitch_data_b", bus_b.readdata, 32'h09);
    idle("db_glitch_cap", 2'd2, 1);
    checkValue("db_glitch_cap_b", bus_b.readdata, 32'h00);
    pins = 8'h0B;
    idle("db_hold", 2'd0, 6);
    checkValue("db_hold_early_b", bus_b.readdata, 32'h09);
    idle("db_hold", 2'd0, 1);
    checkValue("db_hold_data_b", bus_b.readdata, 32'h0B);
    idle("db_hold_cap", 2'd2, 1);
    checkValue("db_hold_cap_b", bus_b.readdata, 32'h02);

    regWrite("mask80", 2'd1, 32'h80);
    regWrite("lvl_clear", 2'd2, 32'hFF);
    pins = 8'h8B;
    idle("lvl_high", 2'd0, 1);
    checkValue("lvl_irq_early_c", {31'h0, irq_c}, 32'h0);
    idle("lvl_high", 2'd0, 1);
    checkValue("lvl_irq_high_c", {31'h0, irq_c}, 32'h1);
    idle("lvl_cap", 2'd2, 2);
    checkValue("lvl_cap_rise_c", bus_c.readdata & 32'h80, 32'h80);
    regWrite("lvl_clear7", 2'd2, 32'h80);
    pins = 8'h0B;
    idle("lvl_low", 2'd2, 2);
    checkValue("lvl_irq_low_c", {31'h0, irq_c}, 32'h0);
    idle("lvl_low", 2'd2, 2);
    checkValue("lvl_cap_fall_c", bus_c.readdata & 32'h80, 32'h80);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] p;
      int         kind;
      p = pins;
      if ($urandom_range(3) == 0)
        p = ($urandom_range(3) == 0) ? 8'($urandom) : (p ^ (8'h01 << $urandom_range(7)));
      kind = int'($urandom_range(7));
      case (kind)
        0, 1:    applyStimulus("rand", p, 2'($urandom), 1'b1, 1'b0, $urandom);
        2:       applyStimulus("rand", p, 2'($urandom), 1'b1, 1'b1, $urandom);
        3:       applyStimulus("rand", p, 2'($urandom), 1'b0, 1'b0, $urandom);
        default: applyStimulus("rand", p, 2'($urandom), 1'b0, 1'b1, $urandom);
      endcase
    end

    regWrite("pre_rst_mask", 2'd1, 32'hFF);
    pins = pins ^ 8'h02;
    idle("pre_rst", 2'd1, 2);
    #2 reset_n = 1'b0;
    #1;
    checkValue("rst_now_rd_a", bus_a.readdata, 32'h0);
    checkValue("rst_now_rd_b", bus_b.readdata, 32'h0);
    checkValue("rst_now_rd_c", bus_c.readdata, 32'h0);
    checkValue("rst_now_irq_a", {31'h0, irq_a}, 32'h0);
    checkValue("rst_now_irq_b", {31'h0, irq_b}, 32'h0);
    checkValue("rst_now_irq_c", {31'h0, irq_c}, 32'h0);
    checkOutput("rst_now");
    pins = 8'hFF;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle("post_rst_mask", 2'd1, 1);
    checkValue("post_rst_mask_a", bus_a.readdata, 32'h0);
    checkValue("post_rst_mask_c", bus_c.readdata, 32'h0);
    idle("post_rst_cap", 2'd2, 2);
    checkValue("post_rst_cap_early_a", bus_a.readdata, 32'h0);
    idle("post_rst_cap", 2'd2, 1);
    checkValue("post_rst_cap_a", bus_a.readdata, 32'hFF);
    checkValue("post_rst_cap_c", bus_c.readdata, 32'hFF);
    idle("post_rst_tail", 2'd2, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
